complex_divider_unit: RTL and testbench
=======================================

COMPLEX_DIVIDER_UNIT -- requirements
Module: complex_divider_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width in bits (even, >= 8).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port reserve  input  1  issue-side reservation of the divider by an issued div op.
REQ-005 SHALL have port cancel  input  1  register-read-side notice that the reserved div was flushed in that stage.
REQ-006 SHALL have port req  input  1  execution-side start request carrying operands.
REQ-007 SHALL have port code  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-008 SHALL have port dividend  input  DATA_WIDTH  operand A.
REQ-009 SHALL have port divisor  input  DATA_WIDTH  operand B.
REQ-010 SHALL have port flush  input  1  pipeline flush of the in-flight div op.
REQ-011 SHALL have port release  input  1  writeback consumed the result.
REQ-012 SHALL have port free  output  1  high only in state FREE; issue logic issues a div only when high.
REQ-013 SHALL have port busy  output  1  high only in state PROCESSING.
REQ-014 SHALL have port resultValid  output  1  high only in state FINISHED.
REQ-015 SHALL have port result  output  DATA_WIDTH  quotient (DIV/DIVU) or remainder (REM/REMU); zero when resultValid low.

Function
REQ-016 SHALL implement states FREE, RESERVED, PROCESSING, FINISHED.
REQ-017 FREE: reserve -> RESERVED; all other inputs ignored.
REQ-018 RESERVED: flush or cancel -> FREE; else req -> PROCESSING with iteration counter 0 and operands/code latched; else stay.
REQ-019 PROCESSING: flush -> FREE; else one restoring radix-2 iteration per cycle; counter == DATA_WIDTH-1 -> FINISHED.
REQ-020 FINISHED: flush or release -> FREE; result held stable until then.
REQ-021 Priority within a cycle: rst > flush > cancel > req/release > reserve; reserve outside FREE ignored.
REQ-022 Latency: req accepted in cycle t -> PROCESSING cycles t+1..t+DATA_WIDTH, resultValid first high in cycle t+DATA_WIDTH+1, independent of operand values.
REQ-023 Signed ops (DIV/REM): divide magnitudes unsigned; quotient negated iff operand signs differ; remainder takes dividend sign.
REQ-024 Divisor zero: quotient all ones, remainder = dividend (all codes), via normal latency.
REQ-025 Signed overflow (dividend = most negative, divisor = -1, DIV/REM): quotient = dividend, remainder 0.
REQ-026 Iteration counter SHALL be clog2(DATA_WIDTH) bits, no wrap beyond DATA_WIDTH-1.
REQ-027 req in FREE, PROCESSING or FINISHED SHALL be ignored with no state change.
REQ-028 A flushed operation SHALL never raise resultValid; a new reserve is accepted in the first cycle back in FREE.

Reset
REQ-029 rst SHALL force FREE, counter 0, latched operands 0 on the next edge regardless of state, including mid-PROCESSING.
REQ-030 After reset: free=1, busy=0, resultValid=0, result=0.

Verification
REQ-031 reserve t0, req t1 DIVU 100/7 -> busy t2..t33, resultValid t34 result 14; REMU same -> 2; release -> free next cycle.
REQ-032 DIV -20/3 -> 0xFFFFFFFA; REM -20/3 -> 0xFFFFFFFE; DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-033 reserve t0, cancel t1 -> free high t2; req t2 ignored (stays FREE); reserve+cancel together in FREE -> RESERVED.
REQ-034 flush at 10th PROCESSING cycle -> FREE next cycle, resultValid never high; reserve that cycle -> RESERVED.
REQ-035 rst mid-PROCESSING and in FINISHED -> all outputs at REQ-030 values next cycle; reserve while RESERVED/PROCESSING -> no effect.
REQ-036 FINISHED held 5 cycles without release -> result stable; flush and release together -> FREE.

Source files
------------

// File: rtl/complex_divider_unit.sv
// Reservable restoring radix-2 divider: one quotient bit per cycle, fixed latency.
// The writeback release input is named release_in because `release` is a SystemVerilog keyword.
module complex_divider_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reserve,
    input  logic                  cancel,
    input  logic                  req,
    input  logic [1:0]            code,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    input  logic                  flush,
    input  logic                  release_in,
    output logic                  free,
    output logic                  busy,
    output logic                  resultValid,
    output logic [DATA_WIDTH-1:0] result
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]  ONE      = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_FREE       = 2'd0,
        S_RESERVED   = 2'd1,
        S_PROCESSING = 2'd2,
        S_FINISHED   = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   quo_q, quo_d;
    logic [W-1:0]   rem_q, rem_d;
    logic [W-1:0]   dvs_q, dvs_d;
    logic [W-1:0]   dvd_q, dvd_d;
    logic           rem_sel_q, rem_sel_d;
    logic           qneg_q, qneg_d;
    logic           rneg_q, rneg_d;
    logic           dz_q, dz_d;
    logic [W-1:0]   result_q, result_d;

    logic [W:0]     rem_shift_s;
    logic [W:0]     trial_s;
    logic           take_s;
    logic [W-1:0]   quo_next_s;
    logic [W-1:0]   rem_next_s;
    logic [W-1:0]   q_fin_s;
    logic [W-1:0]   r_fin_s;
    logic           signed_op_s;

    function automatic logic [W-1:0] neg_val(input logic [W-1:0] v);
        return ~v + ONE;
    endfunction

    // Magnitude of a two's-complement operand; the most negative value maps to itself, read unsigned.
    function automatic logic [W-1:0] mag_val(input logic [W-1:0] v, input logic is_signed);
        return (is_signed && v[W-1]) ? neg_val(v) : v;
    endfunction

    // One restoring step plus the sign/zero-divisor fix-up of the final result.
    always_comb begin
        rem_shift_s = {rem_q, quo_q[W-1]};
        trial_s     = rem_shift_s - {1'b0, dvs_q};
        take_s      = ~trial_s[W];
        quo_next_s  = {quo_q[W-2:0], take_s};
        rem_next_s  = take_s ? trial_s[W-1:0] : rem_shift_s[W-1:0];
        if (dz_q) begin
            q_fin_s = {W{1'b1}};
            r_fin_s = dvd_q;
        end else begin
            q_fin_s = qneg_q ? neg_val(quo_next_s) : quo_next_s;
            r_fin_s = rneg_q ? neg_val(rem_next_s) : rem_next_s;
        end
        signed_op_s = ~code[0];
    end

    // Next-state logic: flush outranks cancel, which outranks req/release, which outrank reserve.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        dvd_d     = dvd_q;
        rem_sel_d = rem_sel_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        dz_d      = dz_q;
        result_d  = result_q;
        case (state_q)
            S_FREE: begin
                if (reserve) begin
                    state_d = S_RESERVED;
                end else begin
                    state_d = S_FREE;
                end
            end
            S_RESERVED: begin
                if (flush || cancel) begin
                    state_d = S_FREE;
                end else if (req) begin
                    state_d   = S_PROCESSING;
                    cnt_d     = '0;
                    quo_d     = mag_val(dividend, signed_op_s);
                    rem_d     = '0;
                    dvs_d     = mag_val(divisor, signed_op_s);
                    dvd_d     = dividend;
                    rem_sel_d = code[1];
                    qneg_d    = signed_op_s & (dividend[W-1] ^ divisor[W-1]);
                    rneg_d    = signed_op_s & dividend[W-1];
                    dz_d      = (divisor == '0);
                end else begin
                    state_d = S_RESERVED;
                end
            end
            S_PROCESSING: begin
                if (flush) begin
                    state_d = S_FREE;
                    cnt_d   = '0;
                end else begin
                    quo_d = quo_next_s;
                    rem_d = rem_next_s;
                    if (cnt_q == CNT_LAST) begin
                        state_d  = S_FINISHED;
                        cnt_d    = '0;
                        result_d = rem_sel_q ? r_fin_s : q_fin_s;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            S_FINISHED: begin
                if (flush || release_in) begin
                    state_d  = S_FREE;
                    result_d = '0;
                end else begin
                    state_d = S_FINISHED;
                end
            end
            default: begin
                state_d  = S_FREE;
                cnt_d    = '0;
                result_d = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FREE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            dvd_q     <= '0;
            rem_sel_q <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            dz_q      <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            dvd_q     <= dvd_d;
            rem_sel_q <= rem_sel_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            dz_q      <= dz_d;
            result_q  <= result_d;
        end
    end

    assign free        = (state_q == S_FREE);
    assign busy        = (state_q == S_PROCESSING);
    assign resultValid = (state_q == S_FINISHED);
    assign result      = result_q;

endmodule

// File: tb/tb_complex_divider_unit.sv
// Directed bench for complex_divider_unit with an expected-result queue and immediate assertions.
module tb_complex_divider_unit;
    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         reserve;
    logic         cancel;
    logic         req;
    logic [1:0]   code;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         flush;
    logic         release_in;
    logic         free;
    logic         busy;
    logic         resultValid;
    logic [W-1:0] result;

    int           checks = 0;
    int           failures = 0;
    logic [W-1:0] exp_q[$];

    complex_divider_unit #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .reserve(reserve), .cancel(cancel), .req(req),
        .code(code), .dividend(dividend), .divisor(divisor), .flush(flush),
        .release_in(release_in), .free(free), .busy(busy),
        .resultValid(resultValid), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour written from the arithmetic definition, not the shift algorithm.
    function automatic logic [W-1:0] ref_div(input logic [1:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        sa = a;
        sb = b;
        if (b == '0) return c[1] ? a : {W{1'b1}};
        if (!c[0]) begin
            if (a == {1'b1, {(W-1){1'b0}}} && b == {W{1'b1}}) return c[1] ? '0 : a;
            return c[1] ? (sa % sb) : (sa / sb);
        end
        return c[1] ? (a % b) : (a / b);
    endfunction

    // Reserve, issue, and wait (bounded) for the result; checks latency and the queued expectation.
    task automatic do_op(input string tag, input logic [1:0] c, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] expv);
        int n;
        int busy_n;
        reserve = 1'b1;
        step();
        reserve = 1'b0;
        chk({tag, "_reserved"}, {61'd0, free, busy, resultValid}, 64'd0);
        req = 1'b1; code = c; dividend = a; divisor = b;
        exp_q.push_back(expv);
        n = 0;
        busy_n = 0;
        do begin
            step();
            req = 1'b0;
            n++;
            if (busy) busy_n++;
        end while (!resultValid && n < 200);
        chk({tag, "_latency"}, 64'(n), 64'(W + 1));
        chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(W));
        chk({tag, "_result"}, {32'd0, result}, {32'd0, exp_q.pop_front()});
    endtask

    task automatic do_release(input string tag);
        release_in = 1'b1;
        step();
        release_in = 1'b0;
        chk({tag, "_free_after_release"}, {62'd0, free, resultValid}, 64'd2);
    endtask

    initial begin : main
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [1:0]   rc;
        logic [W-1:0] held;
        logic         seen;

        rst = 1'b1; reserve = 1'b0; cancel = 1'b0; req = 1'b0; code = 2'b00;
        dividend = '0; divisor = '0; flush = 1'b0; release_in = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("reset_flags", {61'd0, free, busy, resultValid}, 64'd4);
        chk("reset_result", {32'd0, result}, 64'd0);

        do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14);
        do_release("divu_100_7");
        do_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2);
        do_release("remu_100_7");

        do_op("div_m20_3", 2'b00, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA);
        do_release("div_m20_3");
        do_op("rem_m20_3", 2'b10, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE);
        do_release("rem_m20_3");
        do_op("div_5_0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF);
        do_release("div_5_0");
        do_op("remu_5_0", 2'b11, 32'd5, 32'd0, 32'd5);
        do_release("remu_5_0");
        do_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        do_release("div_ovf");
        do_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        do_release("rem_ovf");
        do_op("rem_m7_0", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
        do_release("rem_m7_0");

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = (i < 3) ? 32'($urandom_range(1, 1000)) : $urandom;
            rc = 2'(i % 4);
            do_op($sformatf("rand%0d", i), rc, ra, rb, ref_div(rc, ra, rb));
            do_release($sformatf("rand%0d", i));
        end

        // Cancel from RESERVED, then req/cancel behaviour in FREE.
        reserve = 1'b1;
        step();
        reserve = 1'b0; cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("cancel_free", {63'd0, free}, 64'd1);
        req = 1'b1;
        step();
        req = 1'b0;
        chk("req_in_free_ignored", {62'd0, free, busy}, 64'd2);
        reserve = 1'b1; cancel = 1'b1;
        step();
        reserve = 1'b0; cancel = 1'b0;
        chk("reserve_cancel_in_free", {61'd0, free, busy, resultValid}, 64'd0);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("cancel_back_to_free", {63'd0, free}, 64'd1);

        // Flush on the tenth PROCESSING cycle, then immediate re-reserve.
        reserve = 1'b1;
        step();
        reserve = 1'b0; req = 1'b1; code = 2'b01; dividend = 32'd1000; divisor = 32'd3;
        step();
        req = 1'b0;
        for (int i = 0; i < 9; i++) step();
        chk("busy_before_flush", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_to_free", {61'd0, free, busy, resultValid}, 64'd4);
        reserve = 1'b1;
        step();
        reserve = 1'b0;
        chk("reserve_after_flush", {61'd0, free, busy, resultValid}, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < W + 5; i++) begin
            step();
            seen = seen | resultValid;
        end
        chk("flushed_never_valid", {63'd0, seen}, 64'd0);
        cancel = 1'b1;
        step();
        cancel = 1'b0;

        // Reserve ignored outside FREE; reset mid-PROCESSING.
        reserve = 1'b1;
        step();
        step();
        chk("reserve_in_reserved", {61'd0, free, busy, resultValid}, 64'd0);
        req = 1'b1; code = 2'b00; dividend = 32'd77; divisor = 32'd5;
        step();
        req = 1'b0;
        step();
        step();
        chk("reserve_in_processing", {62'd0, free, busy}, 64'd1);
        reserve = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_proc_flags", {61'd0, free, busy, resultValid}, 64'd4);
        chk("rst_mid_proc_result", {32'd0, result}, 64'd0);

        do_op("pre_rst_fin", 2'b01, 32'd99, 32'd9, 32'd11);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_finished_flags", {61'd0, free, busy, resultValid}, 64'd4);
        chk("rst_finished_result", {32'd0, result}, 64'd0);

        // FINISHED held without release; req/reserve there are ignored.
        do_op("hold", 2'b10, 32'd12345, 32'd100, 32'd45);
        held = result;
        req = 1'b1; reserve = 1'b1;
        for (int i = 0; i < 5; i++) step();
        req = 1'b0; reserve = 1'b0;
        chk("hold_valid", {61'd0, free, busy, resultValid}, 64'd1);
        chk("hold_result_stable", {32'd0, result}, {32'd0, held});
        flush = 1'b1; release_in = 1'b1;
        step();
        flush = 1'b0; release_in = 1'b0;
        chk("flush_release_free", {61'd0, free, busy, resultValid}, 64'd4);
        chk("flush_release_result", {32'd0, result}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
